// File: rtl/level_fifo.sv
// First-word-fall-through FIFO with fill level, almost-full/empty flags, synchronous flush,
// sticky overflow/underflow errors and a peak-level monitor.
module level_fifo #(
   parameter int BUF_SIZE   = 8,
   parameter int DATA_WIDTH = 16,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   input  logic                        wr_i,
   input  logic [DATA_WIDTH-1:0]       wdata_i,
   input  logic                        rd_i,
   output logic [DATA_WIDTH-1:0]       rdata_o,
   output logic                        empty_o,
   output logic                        full_o,
   output logic                        almost_empty_o,
   output logic                        almost_full_o,
   output logic [$clog2(BUF_SIZE):0]   level_o,
   output logic [$clog2(BUF_SIZE):0]   peak_o,
   output logic                        overflow_o,
   output logic                        underflow_o
);

   localparam int AW = $clog2(BUF_SIZE);
   localparam int LW = AW + 1;

   localparam logic [LW-1:0] LVL_FULL = LW'(BUF_SIZE);
   localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
   localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DATA_WIDTH-1:0] mem_q [BUF_SIZE];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [LW-1:0] peak_q, peak_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;

   logic rd_acc;
   logic wr_acc;
   logic not_empty;

   assign not_empty = (level_q != '0);
   assign rd_acc    = rd_i & not_empty;
   // A full FIFO still takes a write when the same edge pops the head.
   assign wr_acc    = wr_i & ((level_q != LVL_FULL) | rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

         case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase

         if (wr_i & ~wr_acc) ovf_d = 1'b1;
         if (rd_i & ~rd_acc) udf_d = 1'b1;
      end

      if (flush_i)                peak_d = '0;
      else if (level_d > peak_q)  peak_d = level_d;
      else                        peak_d = peak_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         peak_q   <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         peak_q   <= peak_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately left out of reset; level gates what is visible.
   always_ff @(posedge clk_i) begin
      if (!flush_i && wr_acc) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o        = not_empty ? mem_q[rd_ptr_q] : '0;
   assign empty_o        = ~not_empty;
   assign full_o         = (level_q == LVL_FULL);
   assign almost_empty_o = (level_q <= LVL_AE);
   assign almost_full_o  = (level_q >= LVL_AF);
   assign level_o        = level_q;
   assign peak_o         = peak_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = udf_q;

endmodule
